fetch_seq_ctrl: RTL and testbench

- Instruction-fetch sequencer for the pipelined CPU.
- Owns the PC and drives the combinational instruction ROM address.
- Captures the returned word into the IF/ID register, with a valid/ready handshake to decode.
- Applies redirects (branch/jump) from EX, squashing the wrong-path instruction.

---
 rtl/fetch_seq_ctrl_pkg.sv | 22 ++
 rtl/fetch_seq_ctrl_perf_sat_counter.sv | 32 +++
 rtl/fetch_seq_ctrl.sv | 113 +++++++++++
 tb/tb_fetch_seq_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_ctrl_pkg.sv
// fetch_seq_ctrl_pkg
// Shared definitions for the instruction-fetch sequencer.
// The package holds the default geometry (address width, instruction width and reset PC),
// the state encoding and the NOP word.
// It has no ports.
package fetch_seq_ctrl_pkg;

  localparam int FETCH_AW       = 6;
  localparam int FETCH_DW       = 32;
  localparam int FETCH_START_PC = 1;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_FETCH = 1'b1;

  localparam logic [FETCH_DW-1:0] INST_NOP = 32'h0;

  typedef enum logic {
    FS_IDLE  = ST_IDLE,
    FS_FETCH = ST_FETCH
  } fetch_state_e;

endpackage

// File: rtl/fetch_seq_ctrl_perf_sat_counter.sv
// perf_sat_counter
// CW-wide event counter that saturates at all-ones.
// It is cleared only by reset.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low clear
//   inc    count one event this cycle
//   cnt    current count
module perf_sat_counter
  import fetch_seq_ctrl_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl
// Instruction-fetch sequencer.
// The module owns the PC and presents it as the ROM address.
// It captures the returned ROM word into the IF/ID register.
// The IF/ID register uses a valid/ready handshake towards decode.
// Redirects from EX override everything else and squash the wrong-path word.
//
// Build option: define FETCH_PERF_EN to add saturating counters.
// One counter counts delivered instructions and the other counts squashed instructions.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   run_en           1 = fetch enabled (level)
//   id_ready         decode accepts IF/ID this cycle
//   redirect_valid   branch-taken / jump from EX
//   redirect_pc      redirect target word address
//   rom_addr         ROM address (= PC register)
//   rom_inst         ROM data, combinational from rom_addr
//   id_valid/id_inst/id_pc   IF/ID register contents
//   busy             sequencer is in FETCH
//   perf_fetch_cnt, perf_flush_cnt   (FETCH_PERF_EN only)
module fetch_seq_ctrl
  import fetch_seq_ctrl_pkg::*;
#(
  parameter int AW       = FETCH_AW,
  parameter int DW       = FETCH_DW,
  parameter int START_PC = FETCH_START_PC
`ifdef FETCH_PERF_EN
  ,
  parameter int CW       = 16
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run_en,
  input  logic          id_ready,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_inst,
  output logic          id_valid,
  output logic [DW-1:0] id_inst,
  output logic [AW-1:0] id_pc,
  output logic          busy
`ifdef FETCH_PERF_EN
  ,
  output logic [CW-1:0] perf_fetch_cnt,
  output logic [CW-1:0] perf_flush_cnt
`endif
);

  fetch_state_e  state;
  logic [AW-1:0] pc_p0;
  logic          advance;
  logic          load_p0;

  // A free or draining IF/ID slot lets a fetching sequencer take the next word.
  // A redirect in the same cycle cancels that load.
  assign advance  = (state == FS_FETCH) & run_en & (~id_valid | id_ready);
  assign load_p0  = advance & ~redirect_valid;
  assign rom_addr = pc_p0;
  assign busy     = (state == FS_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FS_IDLE;
      pc_p0    <= AW'(START_PC);
      id_valid <= 1'b0;
      id_inst  <= DW'(INST_NOP);
      id_pc    <= '0;
    end else begin
      // The state follows run_en on every edge, including redirect cycles.
      state <= run_en ? FS_FETCH : FS_IDLE;

      // PC stage (p0) -> IF/ID stage
      if (redirect_valid) begin
        // A word that decode takes this cycle is consumed before the squash.
        // id_inst and id_pc keep their old contents.
        pc_p0    <= redirect_pc;
        id_valid <= 1'b0;
      end else if (load_p0) begin
        id_inst  <= rom_inst;
        id_pc    <= pc_p0;
        id_valid <= 1'b1;
        pc_p0    <= pc_p0 + AW'(1);
      end else if (id_ready) begin
        id_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic flush_ev;

  // Only a word that decode did not take this cycle counts as squashed.
  assign flush_ev = redirect_valid & id_valid & ~id_ready;

  perf_sat_counter #(.CW(CW)) u_fetch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (load_p0),
    .cnt   (perf_fetch_cnt)
  );

  perf_sat_counter #(.CW(CW)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_ev),
    .cnt   (perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
module tb_fetch_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        run_en;
  logic        id_ready;
  logic        redirect_valid;
  logic [5:0]  redirect_pc;
  logic [5:0]  rom_addr;
  logic [31:0] rom_inst;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [5:0]  id_pc;
  logic        busy;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  logic [31:0] rom [64];
  assign rom_inst = rom[rom_addr];

  fetch_seq_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run_en         (run_en),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .busy           (busy)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // {id_valid, busy, rom_addr, id_pc, id_inst}
  function automatic logic [63:0] obs();
    return {18'd0, id_valid, busy, rom_addr, id_pc, id_inst};
  endfunction

  function automatic logic [63:0] pk(input bit v, input bit b, input logic [5:0] a,
                                     input logic [5:0] p, input logic [31:0] i);
    return {18'd0, v, b, a, p, i};
  endfunction

  typedef struct {
    bit          run;
    bit          rdy;
    bit          rv;
    logic [5:0]  rpc;
    bit          ev;
    logic [5:0]  epc;
    logic [31:0] einst;
    bit          ebusy;
    logic [5:0]  eaddr;
    int          efc;
    int          eflc;
  } vec_t;

  vec_t tbl[24];

  // behavioural reference state
  int          m_pc;
  bit          m_run;
  bit          m_v;
  int          m_ipc;
  logic [31:0] m_inst;
  int          m_fc;
  int          m_flc;

  task automatic model_reset();
    m_pc = 1; m_run = 0; m_v = 0; m_ipc = 0; m_inst = 32'h0; m_fc = 0; m_flc = 0;
  endtask

  task automatic model_step(input bit run, input bit rdy, input bit rv, input int rpc);
    bit take;
    take = m_run && run && (!m_v || rdy);
    if (rv) begin
      if (m_v && !rdy) m_flc = (m_flc < 65535) ? m_flc + 1 : m_flc;
      m_pc = rpc;
      m_v  = 0;
    end else if (take) begin
      m_inst = rom[m_pc];
      m_ipc  = m_pc;
      m_v    = 1;
      m_pc   = (m_pc + 1) % 64;
      m_fc   = (m_fc < 65535) ? m_fc + 1 : m_fc;
    end else if (rdy) begin
      m_v = 0;
    end
    m_run = run;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 | i;
    rom[0]  = 32'h0000_0000;
    rom[1]  = 32'h3800_0866;
    rom[2]  = 32'h3400_0481;
    rom[3]  = 32'h0010_0421;
    rom[11] = 32'h0440_20e5;

    //            run rdy rv rpc    ev epc    einst          busy addr   fc flc
    tbl[0]  = '{1, 1, 0, 6'h00, 0, 6'h00, 32'h0,         1, 6'h01, 0,  0};
    tbl[1]  = '{1, 1, 0, 6'h00, 1, 6'h01, 32'h3800_0866, 1, 6'h02, 1,  0};
    tbl[2]  = '{1, 1, 0, 6'h00, 1, 6'h02, 32'h3400_0481, 1, 6'h03, 2,  0};
    tbl[3]  = '{1, 1, 0, 6'h00, 1, 6'h03, 32'h0010_0421, 1, 6'h04, 3,  0};
    tbl[4]  = '{1, 0, 0, 6'h00, 1, 6'h03, 32'h0010_0421, 1, 6'h04, 3,  0};
    tbl[5]  = '{1, 0, 0, 6'h00, 1, 6'h03, 32'h0010_0421, 1, 6'h04, 3,  0};
    tbl[6]  = '{1, 0, 0, 6'h00, 1, 6'h03, 32'h0010_0421, 1, 6'h04, 3,  0};
    tbl[7]  = '{1, 1, 0, 6'h00, 1, 6'h04, 32'hA000_0004, 1, 6'h05, 4,  0};
    tbl[8]  = '{1, 0, 1, 6'h0B, 0, 6'h04, 32'hA000_0004, 1, 6'h0B, 4,  1};
    tbl[9]  = '{1, 1, 0, 6'h00, 1, 6'h0B, 32'h0440_20e5, 1, 6'h0C, 5,  1};
    tbl[10] = '{1, 1, 1, 6'h13, 0, 6'h0B, 32'h0440_20e5, 1, 6'h13, 5,  1};
    tbl[11] = '{1, 1, 0, 6'h00, 1, 6'h13, 32'hA000_0013, 1, 6'h14, 6,  1};
    tbl[12] = '{1, 0, 1, 6'h01, 0, 6'h13, 32'hA000_0013, 1, 6'h01, 6,  2};
    tbl[13] = '{1, 0, 0, 6'h00, 1, 6'h01, 32'h3800_0866, 1, 6'h02, 7,  2};
    tbl[14] = '{1, 1, 1, 6'h3F, 0, 6'h01, 32'h3800_0866, 1, 6'h3F, 7,  2};
    tbl[15] = '{1, 1, 0, 6'h00, 1, 6'h3F, 32'hA000_003F, 1, 6'h00, 8,  2};
    tbl[16] = '{1, 1, 0, 6'h00, 1, 6'h00, 32'h0000_0000, 1, 6'h01, 9,  2};
    tbl[17] = '{0, 0, 0, 6'h00, 1, 6'h00, 32'h0000_0000, 0, 6'h01, 9,  2};
    tbl[18] = '{0, 0, 0, 6'h00, 1, 6'h00, 32'h0000_0000, 0, 6'h01, 9,  2};
    tbl[19] = '{0, 1, 0, 6'h00, 0, 6'h00, 32'h0000_0000, 0, 6'h01, 9,  2};
    tbl[20] = '{0, 0, 1, 6'h05, 0, 6'h00, 32'h0000_0000, 0, 6'h05, 9,  2};
    tbl[21] = '{1, 0, 0, 6'h00, 0, 6'h00, 32'h0000_0000, 1, 6'h05, 9,  2};
    tbl[22] = '{1, 0, 0, 6'h00, 1, 6'h05, 32'hA000_0005, 1, 6'h06, 10, 2};
    tbl[23] = '{1, 0, 0, 6'h00, 1, 6'h05, 32'hA000_0005, 1, 6'h06, 10, 2};

    // Reset state
    rst_n = 1'b0; run_en = 0; id_ready = 0; redirect_valid = 0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs(), pk(0, 0, 6'h01, 6'h00, 32'h0));
`ifdef FETCH_PERF_EN
    check("reset_perf", {32'd0, perf_fetch_cnt, perf_flush_cnt}, 64'd0);
`endif
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 24; i++) begin
      run_en = tbl[i].run; id_ready = tbl[i].rdy;
      redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), obs(),
            pk(tbl[i].ev, tbl[i].ebusy, tbl[i].eaddr, tbl[i].epc, tbl[i].einst));
`ifdef FETCH_PERF_EN
      check($sformatf("vec%0d_perf", i), {32'd0, perf_fetch_cnt, perf_flush_cnt},
            {32'd0, 16'(tbl[i].efc), 16'(tbl[i].eflc)});
`endif
    end

    // Asynchronous reset during a stall clears the state without a clock edge
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", obs(), pk(0, 0, 6'h01, 6'h00, 32'h0));
`ifdef FETCH_PERF_EN
    check("async_reset_perf", {32'd0, perf_fetch_cnt, perf_flush_cnt}, 64'd0);
`endif
    run_en = 0; id_ready = 0; redirect_valid = 0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Randomized stimulus against the reference model
    for (int c = 0; c < 1500; c++) begin
      run_en         = ($urandom_range(0, 9) != 0);
      id_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = 6'($urandom_range(0, 63));
      model_step(run_en, id_ready, redirect_valid, int'(redirect_pc));
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", c), obs(),
            pk(m_v, m_run, 6'(m_pc), 6'(m_ipc), m_inst));
`ifdef FETCH_PERF_EN
      check($sformatf("rand%0d_perf", c), {32'd0, perf_fetch_cnt, perf_flush_cnt},
            {32'd0, 16'(m_fc), 16'(m_flc)});
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
